// File: rtl/char_pixel_shifter.sv
`default_nettype none
// ============================================================================
// Module   : char_pixel_shifter
// Purpose  : Text-mode cell fetch and dot serialiser. Forms the character ROM
//            address from a cell request, captures the returned glyph byte
//            into a hold register and shifts it out MSB-first as colour
//            indices, one dot per pix_en pulse.
// Revision : 1.0 - initial release
// ============================================================================
module char_pixel_shifter #(
  parameter int ROM_LATENCY = 1  // 1, or 2 with the ROM output register
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        char_valid,
  output logic        char_ready,
  input  logic [7:0]  char_code,
  input  logic [3:0]  char_color,
  input  logic [2:0]  char_row,
  input  logic        charset_sel,
  input  logic [3:0]  bg_color,
  output logic [11:0] rom_addr,
  input  logic [7:0]  rom_data,
  input  logic        pix_en,
  output logic [3:0]  pixel_color,
  output logic        pixel_valid,
  output logic        underflow
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_CAPT = 2'd2
  } state_t;

  // WAIT counts down from ROM_LATENCY-1 to 0 before moving to CAPT
  localparam logic [1:0] c_WAIT_LOAD = 2'(ROM_LATENCY - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_wait_cnt;
  logic [1:0]  w_wait_nxt;
  logic        w_accept;
  logic        w_capture;

  logic [3:0]  r_fetch_color;
  logic        r_hold_full;
  logic [7:0]  r_hold_data;
  logic [3:0]  r_hold_color;
  logic [7:0]  r_shift;
  logic [3:0]  r_count;
  logic [3:0]  r_cur_fg;

  // A new cell is only taken while idle with an empty hold; flush blocks it
  assign char_ready = (r_state == S_IDLE) && !r_hold_full && reset_n;
  assign w_accept   = char_valid && char_ready && !flush;
  assign w_capture  = (r_state == S_CAPT) && !flush;

  // Fetch FSM next-state: IDLE -> WAIT (ROM_LATENCY cycles) -> CAPT -> IDLE
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_WAIT;
          w_wait_nxt  = c_WAIT_LOAD;
        end
      end
      S_WAIT: begin
        if (r_wait_cnt == 2'd0) begin
          w_state_nxt = S_CAPT;
        end else begin
          w_wait_nxt = r_wait_cnt - 2'd1;
        end
      end
      S_CAPT: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (flush) begin
      w_state_nxt = S_IDLE;
    end
  end

  // Fetch FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= 2'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
    end
  end

  // ROM address and foreground colour are latched on the accepting edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_addr      <= 12'd0;
      r_fetch_color <= 4'd0;
    end else if (w_accept) begin
      rom_addr      <= {charset_sel, char_code, char_row};
      r_fetch_color <= char_color;
    end
  end

  // Hold register capture and dot shifter; an empty shifter reloads from
  // hold on the same edge it emits, so back-to-back cells have no gap
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hold_full  <= 1'b0;
      r_hold_data  <= 8'd0;
      r_hold_color <= 4'd0;
      r_shift      <= 8'd0;
      r_count      <= 4'd0;
      r_cur_fg     <= 4'd0;
      pixel_color  <= 4'd0;
      pixel_valid  <= 1'b0;
      underflow    <= 1'b0;
    end else if (flush) begin
      r_hold_full <= 1'b0;
      r_count     <= 4'd0;
      pixel_valid <= 1'b0;
    end else begin
      // capture only happens with an empty hold, load only with a full one
      if (w_capture) begin
        r_hold_data  <= rom_data;
        r_hold_color <= r_fetch_color;
        r_hold_full  <= 1'b1;
      end
      if (pix_en) begin
        if (r_count != 4'd0) begin
          pixel_color <= r_shift[7] ? r_cur_fg : bg_color;
          pixel_valid <= 1'b1;
          r_shift     <= {r_shift[6:0], 1'b0};
          r_count     <= r_count - 4'd1;
        end else if (r_hold_full) begin
          pixel_color <= r_hold_data[7] ? r_hold_color : bg_color;
          pixel_valid <= 1'b1;
          r_shift     <= {r_hold_data[6:0], 1'b0};
          r_cur_fg    <= r_hold_color;
          r_count     <= 4'd7;
          r_hold_full <= 1'b0;
        end else begin
          pixel_color <= bg_color;
          pixel_valid <= 1'b0;
          underflow   <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_char_pixel_shifter.sv
`default_nettype none
// ============================================================================
// Module   : tb_char_pixel_shifter
// Purpose  : Self-checking bench. Two instances (ROM_LATENCY 1 and 2) share
//            the same stimulus; a cell-level model predicts every output of
//            each instance on every cycle, plus literal pinned expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_char_pixel_shifter;

  logic        clk;
  logic        reset_n;
  logic        flush;
  logic        char_valid;
  logic [7:0]  char_code;
  logic [3:0]  char_color;
  logic [2:0]  char_row;
  logic        charset_sel;
  logic [3:0]  bg_color;
  logic        pix_en;

  logic        rdy0, rdy1, pv0, pv1, uf0, uf1;
  logic [11:0] ra0, ra1;
  logic [3:0]  pc0, pc1;
  logic [7:0]  rd0, rd1a, rd1b;

  int n_cmp  = 0;
  int n_fail = 0;

  // character ROM contents: a few fixed glyphs plus an address hash
  function automatic logic [7:0] rom_fn(input logic [11:0] a);
    case (a)
      12'h008: rom_fn = 8'h18;
      12'h009: rom_fn = 8'h3C;
      12'h409: rom_fn = 8'hC3;
      default: rom_fn = 8'(a * 37) ^ 8'(a >> 4);
    endcase
  endfunction

  char_pixel_shifter #(.ROM_LATENCY(1)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .char_valid(char_valid),
    .char_ready(rdy0), .char_code(char_code), .char_color(char_color),
    .char_row(char_row), .charset_sel(charset_sel), .bg_color(bg_color),
    .rom_addr(ra0), .rom_data(rd0), .pix_en(pix_en), .pixel_color(pc0),
    .pixel_valid(pv0), .underflow(uf0)
  );

  char_pixel_shifter #(.ROM_LATENCY(2)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .char_valid(char_valid),
    .char_ready(rdy1), .char_code(char_code), .char_color(char_color),
    .char_row(char_row), .charset_sel(charset_sel), .bg_color(bg_color),
    .rom_addr(ra1), .rom_data(rd1b), .pix_en(pix_en), .pixel_color(pc1),
    .pixel_valid(pv1), .underflow(uf1)
  );

  // synchronous ROMs of latency 1 and 2
  always @(posedge clk) begin
    rd0  <= rom_fn(ra0);
    rd1a <= rom_fn(ra1);
    rd1b <= rd1a;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- cell-level reference model ----------------
  int          m_lat   [2];
  logic        m_busy  [2];
  int          m_left  [2];
  logic [11:0] m_addr  [2];
  logic [3:0]  m_fcol  [2];
  logic        m_hfull [2];
  logic [7:0]  m_hglyph[2];
  logic [3:0]  m_hcol  [2];
  logic [7:0]  m_glyph [2];
  int          m_pos   [2];  // dots of current glyph already shown; 8 = none left
  logic [3:0]  m_fg    [2];
  logic [3:0]  m_pc    [2];
  logic        m_pv    [2];
  logic        m_uf    [2];

  initial begin
    m_lat[0] = 1;
    m_lat[1] = 2;
  end

  function automatic logic m_ready(input int k);
    m_ready = reset_n && !m_busy[k] && !m_hfull[k];
  endfunction

  task automatic m_reset(input int k);
    m_busy[k] = 0; m_left[k] = 0; m_addr[k] = 0; m_fcol[k] = 0;
    m_hfull[k] = 0; m_hglyph[k] = 0; m_hcol[k] = 0; m_glyph[k] = 0;
    m_pos[k] = 8; m_fg[k] = 0; m_pc[k] = 0; m_pv[k] = 0; m_uf[k] = 0;
  endtask

  task automatic m_step(input int k);
    logic acc;
    logic dot;
    if (flush) begin
      m_busy[k] = 0; m_hfull[k] = 0; m_pos[k] = 8; m_pv[k] = 0;
      return;
    end
    acc = char_valid && m_ready(k);
    if (pix_en) begin
      if (m_pos[k] < 8) begin
        dot = m_glyph[k][7 - m_pos[k]];
        m_pc[k] = dot ? m_fg[k] : bg_color; m_pv[k] = 1; m_pos[k]++;
      end else if (m_hfull[k]) begin
        m_glyph[k] = m_hglyph[k]; m_fg[k] = m_hcol[k]; m_hfull[k] = 0;
        m_pc[k] = m_glyph[k][7] ? m_fg[k] : bg_color; m_pv[k] = 1; m_pos[k] = 1;
      end else begin
        m_pc[k] = bg_color; m_pv[k] = 0; m_uf[k] = 1;
      end
    end
    if (m_busy[k]) begin
      if (m_left[k] == 1) begin
        m_hfull[k] = 1; m_hglyph[k] = rom_fn(m_addr[k]); m_hcol[k] = m_fcol[k];
        m_busy[k] = 0;
      end else begin
        m_left[k]--;
      end
    end
    if (acc) begin
      m_busy[k] = 1; m_left[k] = m_lat[k] + 1;
      m_addr[k] = {charset_sel, char_code, char_row}; m_fcol[k] = char_color;
    end
  endtask

  // model advances on the same edges as the design, reset acts immediately
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 2; k++) m_reset(k);
    end else begin
      for (int k = 0; k < 2; k++) m_step(k);
    end
  end

  task automatic chk(input string nm, input int k, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s[L%0d] got %0h expected %0h at %0t", nm, k + 1, act, exp_v, $time);
    end
  endtask

  // per-cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    chk("char_ready",  0, int'(rdy0), int'(m_ready(0)));
    chk("rom_addr",    0, int'(ra0),  int'(m_addr[0]));
    chk("pixel_color", 0, int'(pc0),  int'(m_pc[0]));
    chk("pixel_valid", 0, int'(pv0),  int'(m_pv[0]));
    chk("underflow",   0, int'(uf0),  int'(m_uf[0]));
    chk("char_ready",  1, int'(rdy1), int'(m_ready(1)));
    chk("rom_addr",    1, int'(ra1),  int'(m_addr[1]));
    chk("pixel_color", 1, int'(pc1),  int'(m_pc[1]));
    chk("pixel_valid", 1, int'(pv1),  int'(m_pv[1]));
    chk("underflow",   1, int'(uf1),  int'(m_uf[1]));
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic set_cell(input logic [7:0] c, input logic [3:0] col,
                          input logic [2:0] r, input logic s);
    char_code = c; char_color = col; char_row = r; charset_sel = s;
  endtask

  // watchdog: the bench has no open-ended waits, this only guards time
  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [3:0] exp_dots [8];

  initial begin
    reset_n = 0; flush = 0; char_valid = 0; pix_en = 0; bg_color = 4'd6;
    set_cell(8'h00, 4'd0, 3'd0, 1'b0);
    repeat (3) cyc();
    chk("lit_reset_ready", 0, int'(rdy0), 0);
    chk("lit_reset_addr",  0, int'(ra0), 0);
    chk("lit_reset_pv",    1, int'(pv1), 0);
    reset_n = 1;
    cyc();

    // single fetch: glyph 0x18, fg=1, bg=6
    exp_dots = '{4'd6, 4'd6, 4'd6, 4'd1, 4'd1, 4'd6, 4'd6, 4'd6};
    set_cell(8'h01, 4'd1, 3'd0, 1'b0);
    char_valid = 1;
    cyc();
    char_valid = 0;
    @(negedge clk);
    chk("lit_addr_008", 0, int'(ra0), 12'h008);
    chk("lit_addr_008", 1, int'(ra1), 12'h008);
    repeat (3) cyc();
    pix_en = 1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (i == 7) pix_en = 0;
      @(negedge clk);
      chk("lit_dot", 0, int'(pc0), int'(exp_dots[i]));
      chk("lit_dot", 1, int'(pc1), int'(exp_dots[i]));
      chk("lit_dot_valid", 0, int'(pv0), 1);
    end

    // streaming: 0x01 then 0x81 on row 1, dots every clock
    set_cell(8'h01, 4'd2, 3'd1, 1'b0);
    char_valid = 1;
    cyc();
    set_cell(8'h81, 4'd3, 3'd1, 1'b0);
    repeat (3) cyc();
    pix_en = 1;
    for (int i = 0; i < 16; i++) begin
      cyc();
      @(negedge clk);
      chk("lit_stream_valid", 0, int'(pv0), 1);
      chk("lit_stream_valid", 1, int'(pv1), 1);
    end
    chk("lit_stream_addr", 0, int'(ra0), 12'h409);
    chk("lit_stream_addr", 1, int'(ra1), 12'h409);
    chk("lit_stream_uf", 0, int'(uf0), 0);
    chk("lit_stream_uf", 1, int'(uf1), 0);
    char_valid = 0; pix_en = 0; flush = 1;
    cyc();
    flush = 0;

    // bank and row
    set_cell(8'h02, 4'd5, 3'd7, 1'b1);
    char_valid = 1;
    cyc();
    char_valid = 0;
    @(negedge clk);
    chk("lit_addr_817", 0, int'(ra0), 12'h817);
    chk("lit_addr_817", 1, int'(ra1), 12'h817);
    repeat (4) cyc();
    pix_en = 1;
    repeat (8) cyc();
    pix_en = 0;

    // flush during WAIT, then dots with nothing loaded
    set_cell(8'h41, 4'd7, 3'd2, 1'b0);
    char_valid = 1;
    cyc();
    char_valid = 0; flush = 1;
    cyc();
    flush = 0;
    @(negedge clk);
    chk("lit_flush_ready", 0, int'(rdy0), 1);
    chk("lit_flush_ready", 1, int'(rdy1), 1);
    bg_color = 4'd9; pix_en = 1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      @(negedge clk);
      chk("lit_flush_pv", 0, int'(pv0), 0);
      chk("lit_flush_pv", 1, int'(pv1), 0);
    end
    chk("lit_uf_color", 0, int'(pc0), 9);
    chk("lit_uf_set", 0, int'(uf0), 1);
    pix_en = 0;

    // underflow stays set after a later valid cell
    set_cell(8'h10, 4'd4, 3'd3, 1'b1);
    char_valid = 1;
    cyc();
    char_valid = 0;
    repeat (4) cyc();
    pix_en = 1;
    repeat (3) cyc();
    @(negedge clk);
    chk("lit_uf_sticky", 0, int'(uf0), 1);
    chk("lit_uf_sticky", 1, int'(uf1), 1);

    // asynchronous reset mid-cell
    @(posedge clk);
    #3;
    reset_n = 0;
    #1;
    chk("lit_areset_ready", 0, int'(rdy0), 0);
    chk("lit_areset_addr",  0, int'(ra0), 0);
    chk("lit_areset_pv",    1, int'(pv1), 0);
    chk("lit_areset_uf",    0, int'(uf0), 0);
    chk("lit_areset_pc",    1, int'(pc1), 0);
    pix_en = 0;
    repeat (2) cyc();
    reset_n = 1;
    cyc();

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      char_valid = 1'($urandom_range(0, 1));
      set_cell(8'($urandom), 4'($urandom), 3'($urandom), 1'($urandom));
      bg_color = 4'($urandom);
      pix_en   = ($urandom_range(0, 7) != 0);
      flush    = ($urandom_range(0, 63) == 0);
      if (i == 2000) reset_n = 0;
      if (i == 2003) reset_n = 1;
      cyc();
    end
    char_valid = 0; pix_en = 0; flush = 0;
    repeat (2) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
